// File: rtl/minifloat_divider_if.sv
// Operand/result strobe bus shared by the 8-bit minifloat arithmetic units.
interface minifloat_divider_if;
  logic [7:0] input_a;
  logic       input_a_stb;
  logic       input_a_ack;
  logic [7:0] input_b;
  logic       input_b_stb;
  logic       input_b_ack;
  logic [7:0] output_z;
  logic       output_z_stb;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/minifloat_divider.sv
// Sequential 8-bit minifloat divider: strobe handshake, bit-serial restoring
// divide, round-to-nearest-even with denormal results.
module minifloat_divider #(
  parameter int EXP_BIAS = 3,
  parameter int QBITS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  minifloat_divider_if.slave bus
);
  localparam int CW = $clog2(QBITS);
  localparam logic signed [5:0] BIAS6 = 6'(EXP_BIAS);
  localparam logic signed [5:0] EMIN  = 6'(1 - EXP_BIAS);
  localparam logic signed [5:0] EMAX  = 6'(6 - EXP_BIAS);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B,
    DIV, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        a_q, b_q, output_z_q;
  logic              sa_q, sb_q, zs_q;
  logic [4:0]        ma_q, mb_q, zm_q;
  logic signed [5:0] ea_q, eb_q, ze_q;
  logic [6:0]        rem_q;
  logic [QBITS-1:0]  q_q;
  logic [CW-1:0]     cnt_q;
  logic              guard_q, round_q, sticky_q;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic is_nan, is_inf, is_zero, z_sign;
  logic              q_bit;
  logic [5:0]        rem_sub;
  logic [2:0]        exp_field;
  logic [7:0]        packed_z;

  function automatic logic signed [5:0] unbias(input logic [2:0] e);
    return (e == 3'd0) ? EMIN : $signed({3'b000, e}) - BIAS6;
  endfunction

  assign a_nan  = (&a_q[6:4]) & (|a_q[3:0]);
  assign b_nan  = (&b_q[6:4]) & (|b_q[3:0]);
  assign a_inf  = (&a_q[6:4]) & ~(|a_q[3:0]);
  assign b_inf  = (&b_q[6:4]) & ~(|b_q[3:0]);
  assign a_zero = ~(|a_q[6:0]);
  assign b_zero = ~(|b_q[6:0]);
  assign z_sign = a_q[7] ^ b_q[7];

  assign is_nan  = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);
  assign is_inf  = a_inf | b_zero;
  assign is_zero = a_zero | b_inf;

  // One restoring step: trial-subtract the divisor, keep the result only if it fits.
  assign q_bit   = rem_q >= {2'b00, mb_q};
  assign rem_sub = q_bit ? 6'(rem_q - {2'b00, mb_q}) : rem_q[5:0];

  assign exp_field = 3'(ze_q + BIAS6);

  always_comb begin
    if (ze_q > EMAX)
      packed_z = {zs_q, 3'b111, 4'b0000};
    else if (ze_q == EMIN && !zm_q[4])
      packed_z = {zs_q, 3'b000, zm_q[3:0]};
    else
      packed_z = {zs_q, exp_field, zm_q[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= GET_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:   if (bus.input_a_stb) state_d = GET_B;
      GET_B:   if (bus.input_b_stb) state_d = UNPACK;
      UNPACK:  state_d = SPECIAL;
      SPECIAL: state_d = (is_nan | is_inf | is_zero) ? PUT_Z : NORM_A;
      NORM_A:  if (ma_q[4]) state_d = NORM_B;
      NORM_B:  if (mb_q[4]) state_d = DIV;
      DIV:     if (cnt_q == CW'(QBITS - 1)) state_d = NORM_1;
      NORM_1:  state_d = NORM_2;
      NORM_2:  if (ze_q >= EMIN) state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = PUT_Z;
      PUT_Z:   state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_comb begin
    bus.input_a_ack  = !rst && (state_q == GET_A) && bus.input_a_stb;
    bus.input_b_ack  = !rst && (state_q == GET_B) && bus.input_b_stb;
    bus.output_z_stb = !rst && (state_q == PUT_Z);
  end

  assign bus.output_z = output_z_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      output_z_q <= 8'h00;
    end else begin
      case (state_q)
        GET_A: if (bus.input_a_stb) a_q <= bus.input_a;
        GET_B: if (bus.input_b_stb) b_q <= bus.input_b;
        UNPACK: begin
          sa_q <= a_q[7];
          sb_q <= b_q[7];
          ma_q <= {|a_q[6:4], a_q[3:0]};
          mb_q <= {|b_q[6:4], b_q[3:0]};
          ea_q <= unbias(a_q[6:4]);
          eb_q <= unbias(b_q[6:4]);
        end
        SPECIAL: begin
          if (is_nan)       output_z_q <= 8'hF8;
          else if (is_inf)  output_z_q <= {z_sign, 7'h70};
          else if (is_zero) output_z_q <= {z_sign, 7'h00};
        end
        NORM_A: if (!ma_q[4]) begin
          ma_q <= {ma_q[3:0], 1'b0};
          ea_q <= ea_q - 6'sd1;
        end
        NORM_B: begin
          if (!mb_q[4]) begin
            mb_q <= {mb_q[3:0], 1'b0};
            eb_q <= eb_q - 6'sd1;
          end else begin
            zs_q  <= sa_q ^ sb_q;
            ze_q  <= ea_q - eb_q;
            rem_q <= {2'b00, ma_q};
            cnt_q <= '0;
          end
        end
        DIV: begin
          q_q   <= {q_q[QBITS-2:0], q_bit};
          rem_q <= {rem_sub, 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        NORM_1: begin
          if (q_q[7]) begin
            zm_q     <= q_q[7:3];
            guard_q  <= q_q[2];
            round_q  <= q_q[1];
            sticky_q <= q_q[0] | (|rem_q);
          end else begin
            zm_q     <= q_q[6:2];
            guard_q  <= q_q[1];
            round_q  <= q_q[0];
            sticky_q <= |rem_q;
            ze_q     <= ze_q - 6'sd1;
          end
        end
        // Denormalise toward the smallest exponent, keeping every shifted-out bit.
        NORM_2: if (ze_q < EMIN) begin
          ze_q     <= ze_q + 6'sd1;
          zm_q     <= {1'b0, zm_q[4:1]};
          guard_q  <= zm_q[0];
          round_q  <= guard_q;
          sticky_q <= sticky_q | round_q;
        end
        ROUND: if (guard_q & (round_q | sticky_q | zm_q[0])) begin
          if (&zm_q) begin
            zm_q <= 5'b10000;
            ze_q <= ze_q + 6'sd1;
          end else begin
            zm_q <= zm_q + 5'd1;
          end
        end
        PACK: output_z_q <= packed_z;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_minifloat_divider.sv
// Self-checking bench for minifloat_divider: directed vectors, handshake,
// reset mid-operation, and random operands against an exact-arithmetic model.
module tb_minifloat_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  minifloat_divider_if bus();

  minifloat_divider #(.EXP_BIAS(3), .QBITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exact quotient rounded to nearest-even in the 8-bit format.
  function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    logic s;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint va, vb, num, den, n, r;
    int k;
    logic [2:0] ef;
    s      = a[7] ^ b[7];
    a_nan  = (a[6:4] == 3'd7) && (a[3:0] != 4'd0);
    b_nan  = (b[6:4] == 3'd7) && (b[3:0] != 4'd0);
    a_inf  = (a[6:4] == 3'd7) && (a[3:0] == 4'd0);
    b_inf  = (b[6:4] == 3'd7) && (b[3:0] == 4'd0);
    a_zero = (a[6:0] == 7'd0);
    b_zero = (b[6:0] == 7'd0);
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return 8'hF8;
    if (a_inf || b_zero) return {s, 7'h70};
    if (a_zero || b_inf) return {s, 7'h00};
    va = longint'(a[3:0]) + ((a[6:4] != 3'd0) ? 64'd16 : 64'd0);
    vb = longint'(b[3:0]) + ((b[6:4] != 3'd0) ? 64'd16 : 64'd0);
    va = va << ((a[6:4] == 3'd0) ? 6 : int'(a[6:4]) + 5);
    vb = vb << ((b[6:4] == 3'd0) ? 6 : int'(b[6:4]) + 5);
    k = -2;
    while (k < 12 && (va << 2) >= (vb << (k + 3))) k++;
    if (k <= 4) begin num = va << (4 - k); den = vb; end
    else        begin num = va; den = vb << (k - 4); end
    n = num / den;
    r = num - n * den;
    if (2 * r > den || (2 * r == den && (n % 2) == 1)) n++;
    if (n == 32) begin n = 16; k++; end
    if (k > 3) return {s, 7'h70};
    if (n < 16) return {s, 3'b000, 4'(n)};
    ef = 3'(k + 3);
    return {s, ef, 4'(n)};
  endfunction

  task automatic send_a(input logic [7:0] a, output int waited, output bit ok);
    bus.input_a = a;
    bus.input_a_stb = 1'b1;
    #1;
    waited = 0;
    while (bus.input_a_ack !== 1'b1 && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    ok = (bus.input_a_ack === 1'b1);
    @(negedge clk);
    bus.input_a_stb = 1'b0;
  endtask

  task automatic send_b_get_z(input logic [7:0] b, output logic [7:0] z,
                              output int lat, output bit ok);
    int w;
    bus.input_b = b;
    bus.input_b_stb = 1'b1;
    #1;
    w = 0;
    while (bus.input_b_ack !== 1'b1 && w < 50) begin
      @(negedge clk); #1; w++;
    end
    ok = (bus.input_b_ack === 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      bus.input_b_stb = 1'b0;
      #1;
      lat++;
    end while (bus.output_z_stb !== 1'b1 && lat < 60);
    ok = ok && (bus.output_z_stb === 1'b1);
    z = bus.output_z;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] z, output int lat, output bit ok);
    int w;
    bit ok_a, ok_b;
    @(negedge clk);
    send_a(a, w, ok_a);
    send_b_get_z(b, z, lat, ok_b);
    ok = ok_a && ok_b;
  endtask

  task automatic test_reset();
    bus.input_a = 8'h40; bus.input_b = 8'h30;
    bus.input_a_stb = 1'b1; bus.input_b_stb = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.output_z !== 8'h00) begin
      errors++; $display("FAIL reset_z: got %02h want 00", bus.output_z);
    end
    checks++;
    if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b0 || bus.input_b_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got z_stb=%b a_ack=%b b_ack=%b want 0 0 0",
               bus.output_z_stb, bus.input_a_ack, bus.input_b_ack);
    end
    bus.input_a_stb = 1'b0; bus.input_b_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("reset: output_z=%02h", bus.output_z);
  endtask

  task automatic test_basic();
    logic [7:0] ta[5] = '{8'h40, 8'h48, 8'hB0, 8'h30, 8'h30};
    logic [7:0] tb[5] = '{8'h30, 8'h40, 8'h40, 8'h48, 8'h31};
    logic [7:0] te[5] = '{8'h40, 8'h38, 8'hA0, 8'h15, 8'h2E};
    logic [7:0] z;
    int lat, extra;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], z, lat, ok);
      checks++;
      if (!ok || z !== te[i]) begin
        errors++; $display("FAIL basic %02h/%02h: got %02h (ok=%0d) want %02h", ta[i], tb[i], z, ok, te[i]);
      end else $display("basic %02h/%02h = %02h lat=%0d", ta[i], tb[i], z, lat);
      extra = 0;
      repeat (4) begin @(negedge clk); #1; extra += int'(bus.output_z_stb); end
      checks++;
      if (extra != 0) begin
        errors++; $display("FAIL single_pulse %02h/%02h: got %0d extra strobes want 0", ta[i], tb[i], extra);
      end
      checks++;
      if (bus.output_z !== te[i]) begin
        errors++; $display("FAIL hold_z: got %02h want %02h", bus.output_z, te[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [7:0] ta[6] = '{8'h30, 8'h00, 8'h70, 8'h79, 8'h30, 8'hB0};
    logic [7:0] tb[6] = '{8'h00, 8'h00, 8'h70, 8'h30, 8'h70, 8'h00};
    logic [7:0] te[6] = '{8'h70, 8'hF8, 8'hF8, 8'hF8, 8'h00, 8'hF0};
    logic [7:0] z;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], z, lat, ok);
      checks++;
      if (!ok || z !== te[i] || lat > 3) begin
        errors++;
        $display("FAIL special %02h/%02h: got %02h lat=%0d (ok=%0d) want %02h lat<=3", ta[i], tb[i], z, lat, ok, te[i]);
      end else $display("special %02h/%02h = %02h lat=%0d", ta[i], tb[i], z, lat);
    end
  endtask

  task automatic test_range();
    logic [7:0] ta[3] = '{8'h6F, 8'h10, 8'h01};
    logic [7:0] tb[3] = '{8'h10, 8'h60, 8'h30};
    logic [7:0] te[3] = '{8'h70, 8'h02, 8'h01};
    logic [7:0] z;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], z, lat, ok);
      checks++;
      if (!ok || z !== te[i]) begin
        errors++; $display("FAIL range %02h/%02h: got %02h (ok=%0d) want %02h", ta[i], tb[i], z, ok, te[i]);
      end else $display("range %02h/%02h = %02h lat=%0d", ta[i], tb[i], z, lat);
    end
  endtask

  task automatic test_handshake();
    int a_acks, b_acks, cyc;
    bit got;
    logic [7:0] z;
    @(negedge clk);
    bus.input_a = 8'h48; bus.input_b = 8'h40;
    bus.input_b_stb = 1'b1;
    #1;
    checks++;
    if (bus.input_b_ack !== 1'b0) begin
      errors++; $display("FAIL early_b_ack: got %b want 0", bus.input_b_ack);
    end
    @(negedge clk);
    bus.input_a_stb = 1'b1;
    #1;
    a_acks = 0; b_acks = 0; cyc = 0; got = 1'b0; z = 8'h00;
    while (cyc < 60) begin
      a_acks += int'(bus.input_a_ack);
      b_acks += int'(bus.input_b_ack);
      if (bus.output_z_stb === 1'b1) begin got = 1'b1; z = bus.output_z; break; end
      if (cyc == 4) begin bus.input_a_stb = 1'b0; bus.input_b_stb = 1'b0; end
      @(negedge clk); #1; cyc++;
    end
    checks++;
    if (a_acks != 1 || b_acks != 1) begin
      errors++; $display("FAIL held_strobes: got a_acks=%0d b_acks=%0d want 1 1", a_acks, b_acks);
    end
    checks++;
    if (!got || z !== 8'h38) begin
      errors++; $display("FAIL handshake_result: got %02h (seen=%0d) want 38", z, got);
    end else $display("handshake 48/40 = %02h acks a=%0d b=%0d", z, a_acks, b_acks);
  endtask

  task automatic test_reset_mid_div();
    int w, stbs;
    bit ok;
    logic [7:0] z;
    int lat;
    @(negedge clk);
    send_a(8'h48, w, ok);
    bus.input_b = 8'h40;
    bus.input_b_stb = 1'b1;
    #1;
    w = 0;
    while (bus.input_b_ack !== 1'b1 && w < 50) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    bus.input_b_stb = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stbs = 0;
    repeat (40) begin @(negedge clk); #1; stbs += int'(bus.output_z_stb); end
    checks++;
    if (stbs != 0 || bus.output_z !== 8'h00) begin
      errors++; $display("FAIL reset_mid_div: got stbs=%0d z=%02h want 0 00", stbs, bus.output_z);
    end else $display("reset mid-DIV: no strobe, output_z=%02h", bus.output_z);
    do_op(8'h30, 8'h48, z, lat, ok);
    checks++;
    if (!ok || z !== 8'h15) begin
      errors++; $display("FAIL after_reset: got %02h (ok=%0d) want 15", z, ok);
    end else $display("after reset 30/48 = %02h", z);
  endtask

  task automatic test_back_to_back();
    logic [7:0] z;
    int lat, w;
    bit ok, ok_a, ok_b;
    do_op(8'h40, 8'h30, z, lat, ok);
    checks++;
    if (!ok || z !== 8'h40) begin
      errors++; $display("FAIL b2b_first: got %02h want 40", z);
    end
    send_a(8'h48, w, ok_a);
    checks++;
    if (!ok_a || w != 1) begin
      errors++; $display("FAIL b2b_a_accept: got %0d cycles after strobe want 1", w);
    end
    send_b_get_z(8'h40, z, lat, ok_b);
    checks++;
    if (!ok_b || z !== 8'h38) begin
      errors++; $display("FAIL b2b_second: got %02h want 38", z);
    end else $display("back-to-back 48/40 = %02h a accepted %0d cycle after z", z, w);
  endtask

  task automatic test_random();
    logic [7:0] a, b, z, exp_z;
    int lat;
    bit ok, both_normal;
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_z = ref_div(a, b);
      do_op(a, b, z, lat, ok);
      checks++;
      if (!ok || z !== exp_z) begin
        errors++; $display("FAIL random %02h/%02h: got %02h (ok=%0d) want %02h", a, b, z, ok, exp_z);
      end else $display("random %02h/%02h = %02h lat=%0d", a, b, z, lat);
      both_normal = (a[6:4] != 3'd0) && (a[6:4] != 3'd7) && (b[6:4] != 3'd0) && (b[6:4] != 3'd7);
      if (both_normal) begin
        checks++;
        if (lat > 27) begin
          errors++; $display("FAIL latency %02h/%02h: got %0d want <=27", a, b, lat);
        end
      end
    end
  endtask

  initial begin
    bus.input_a = 8'h00; bus.input_b = 8'h00;
    bus.input_a_stb = 1'b0; bus.input_b_stb = 1'b0;
    test_reset();
    test_basic();
    test_specials();
    test_range();
    test_handshake();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
